// File: rtl/ahbl_pkg.sv
// AHB-lite encodings shared by the splitter fabric.
// Transfer types, response codes and the decode-error response FSM states.
package ahbl_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_t;
endpackage

// File: rtl/onehot_mux.sv
// One-hot AND-OR mux: N inputs of W bits, all-zero select gives zero.
// Purely combinational, no flow control.
module onehot_mux #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      dout = dout | (din[i*W +: W] & {W{sel[i]}});
    end
  end
endmodule

// File: rtl/ahbl_splitter_burst.sv
// AHB-lite 1:N splitter with burst-locked routing and two-cycle decode-error response.
// Address phase routes in zero cycles; responses come only from registered data-phase state.
module ahbl_splitter_burst
  import ahbl_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = 64'h20000000_00000000,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = 64'hf0000000_f0000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        src_hready,
  output logic                        src_hready_resp,
  output logic                        src_hresp,
  input  logic [W_ADDR-1:0]           src_haddr,
  input  logic                        src_hwrite,
  input  logic [1:0]                  src_htrans,
  input  logic [2:0]                  src_hsize,
  input  logic [2:0]                  src_hburst,
  input  logic [3:0]                  src_hprot,
  input  logic                        src_hmastlock,
  input  logic [W_DATA-1:0]           src_hwdata,
  output logic [W_DATA-1:0]           src_hrdata,
  output logic [N_PORTS-1:0]          dst_hready,
  input  logic [N_PORTS-1:0]          dst_hready_resp,
  input  logic [N_PORTS-1:0]          dst_hresp,
  output logic [N_PORTS*W_ADDR-1:0]   dst_haddr,
  output logic [N_PORTS-1:0]          dst_hwrite,
  output logic [N_PORTS*2-1:0]        dst_htrans,
  output logic [N_PORTS*3-1:0]        dst_hsize,
  output logic [N_PORTS*3-1:0]        dst_hburst,
  output logic [N_PORTS*4-1:0]        dst_hprot,
  output logic [N_PORTS-1:0]          dst_hmastlock,
  output logic [N_PORTS*W_DATA-1:0]   dst_hwdata,
  input  logic [N_PORTS*W_DATA-1:0]   dst_hrdata
);
  logic [N_PORTS-1:0] match, pri_sel, cur_sel, sel_d, lock_sel, mux_sel;
  logic               cur_err, err_d, lock_err, no_match, found;
  err_state_t         state;

  always_comb begin
    match   = '0;
    pri_sel = '0;
    found   = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      match[i] = ((src_haddr ^ ADDR_MAP[i*W_ADDR +: W_ADDR]) & ADDR_MASK[i*W_ADDR +: W_ADDR]) == '0;
      if (match[i] && !found) begin
        pri_sel[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign no_match = ~|match;

  // Only NONSEQ decodes; burst continuation beats follow the locked choice.
  always_comb begin
    cur_sel = '0;
    cur_err = 1'b0;
    case (src_htrans)
      HTRANS_NONSEQ: begin
        cur_sel = pri_sel;
        cur_err = no_match;
      end
      HTRANS_SEQ: begin
        cur_sel = lock_sel;
        cur_err = lock_err;
      end
      HTRANS_BUSY: cur_sel = lock_sel;
      HTRANS_IDLE: cur_sel = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      dst_htrans[i*2 +: 2] = cur_sel[i] ? src_htrans : HTRANS_IDLE;
    end
  end

  assign dst_hready    = {N_PORTS{src_hready}};
  assign dst_haddr     = {N_PORTS{src_haddr}};
  assign dst_hwrite    = {N_PORTS{src_hwrite}};
  assign dst_hsize     = {N_PORTS{src_hsize}};
  assign dst_hburst    = {N_PORTS{src_hburst}};
  assign dst_hprot     = {N_PORTS{src_hprot}};
  assign dst_hmastlock = {N_PORTS{src_hmastlock}};
  assign dst_hwdata    = {N_PORTS{src_hwdata}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_OK;
      sel_d    <= '0;
      err_d    <= 1'b0;
      lock_sel <= '0;
      lock_err <= 1'b0;
    end else begin
      if (src_hready) begin
        sel_d <= cur_sel;
        err_d <= cur_err;
        if (src_htrans == HTRANS_NONSEQ) begin
          lock_sel <= pri_sel;
          lock_err <= no_match;
        end
      end
      case (state)
        ST_OK:   if (src_hready && cur_err) state <= ST_ERR1;
        ST_ERR1: state <= ST_ERR2;
        ST_ERR2: state <= (src_hready && cur_err) ? ST_ERR1 : ST_OK;
        default: state <= ST_OK;
      endcase
    end
  end

  always_comb begin
    src_hready_resp = 1'b1;
    src_hresp       = HRESP_OKAY;
    case (state)
      ST_OK: begin
        src_hready_resp = ~|sel_d | |(sel_d & dst_hready_resp);
        src_hresp       = |(sel_d & dst_hresp);
      end
      ST_ERR1: begin
        src_hready_resp = 1'b0;
        src_hresp       = HRESP_ERROR;
      end
      ST_ERR2: begin
        src_hready_resp = 1'b1;
        src_hresp       = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  // A decode-error data phase never drives read data.
  assign mux_sel = err_d ? '0 : sel_d;

  onehot_mux #(.N(N_PORTS), .W(W_DATA)) u_rdata_mux (
    .sel  (mux_sel),
    .din  (dst_hrdata),
    .dout (src_hrdata)
  );
endmodule

// File: tb/tb_ahbl_splitter_burst.sv
// Bench for ahbl_splitter_burst: pipelined bus driver, two wait-state slave models,
// scoreboard of expected data-phase responses and per-beat routing.
module tb_ahbl_splitter_burst;
  import ahbl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_hready, src_hready_resp, src_hresp;
  logic [31:0] src_haddr, src_hwdata, src_hrdata;
  logic        src_hwrite, src_hmastlock;
  logic [1:0]  src_htrans;
  logic [2:0]  src_hsize, src_hburst;
  logic [3:0]  src_hprot;
  logic [1:0]  dst_hready, dst_hready_resp, dst_hresp, dst_hwrite, dst_hmastlock;
  logic [63:0] dst_haddr, dst_hwdata, dst_hrdata;
  logic [3:0]  dst_htrans;
  logic [5:0]  dst_hsize, dst_hburst;
  logic [7:0]  dst_hprot;

  // Second instance with fully overlapping decode windows.
  logic        ovl_hready_resp, ovl_hresp;
  logic [31:0] ovl_hrdata;
  logic [1:0]  ovl_hready, ovl_hwrite, ovl_hmastlock;
  logic [63:0] ovl_haddr, ovl_hwdata;
  logic [3:0]  ovl_htrans;
  logic [5:0]  ovl_hsize, ovl_hburst;
  logic [7:0]  ovl_hprot;

  logic [3:0]  wait_cfg [2];
  logic        err_cfg  [2];
  logic [3:0]  cnt      [2];
  logic        act      [2];
  logic [31:0] rdata_cfg[2];

  typedef struct packed {
    logic [7:0]  stalls;
    logic        resp1;
    logic        resp2;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        exp_q[$], obs_q[$];
  logic [3:0]  exp_route_q[$], obs_route_q[$];
  logic [1:0]  bt_q[$];
  logic [31:0] ba_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  assign src_hready = src_hready_resp;
  assign dst_hrdata = {rdata_cfg[1], rdata_cfg[0]};

  ahbl_splitter_burst dut (
    .clk(clk), .rst(rst), .src_hready(src_hready), .src_hready_resp(src_hready_resp),
    .src_hresp(src_hresp), .src_haddr(src_haddr), .src_hwrite(src_hwrite),
    .src_htrans(src_htrans), .src_hsize(src_hsize), .src_hburst(src_hburst),
    .src_hprot(src_hprot), .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata),
    .src_hrdata(src_hrdata), .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp),
    .dst_hresp(dst_hresp), .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite),
    .dst_htrans(dst_htrans), .dst_hsize(dst_hsize), .dst_hburst(dst_hburst),
    .dst_hprot(dst_hprot), .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata),
    .dst_hrdata(dst_hrdata)
  );

  ahbl_splitter_burst #(.ADDR_MASK(64'h0)) dut_ovl (
    .clk(clk), .rst(rst), .src_hready(ovl_hready_resp), .src_hready_resp(ovl_hready_resp),
    .src_hresp(ovl_hresp), .src_haddr(src_haddr), .src_hwrite(src_hwrite),
    .src_htrans(src_htrans), .src_hsize(src_hsize), .src_hburst(src_hburst),
    .src_hprot(src_hprot), .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata),
    .src_hrdata(ovl_hrdata), .dst_hready(ovl_hready), .dst_hready_resp(2'b11),
    .dst_hresp(2'b00), .dst_haddr(ovl_haddr), .dst_hwrite(ovl_hwrite),
    .dst_htrans(ovl_htrans), .dst_hsize(ovl_hsize), .dst_hburst(ovl_hburst),
    .dst_hprot(ovl_hprot), .dst_hmastlock(ovl_hmastlock), .dst_hwdata(ovl_hwdata),
    .dst_hrdata(64'h0)
  );

  // Slave models: configurable wait states, optional error held through the data phase.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] <= 1'b0;
        cnt[i] <= 4'd0;
      end else if (dst_hready[i]) begin
        act[i] <= dst_htrans[2*i+1];
        cnt[i] <= dst_htrans[2*i+1] ? wait_cfg[i] : 4'd0;
      end else if (cnt[i] != 4'd0) begin
        cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dst_hready_resp[i] = (cnt[i] == 4'd0);
      dst_hresp[i]       = act[i] & err_cfg[i];
    end
  end

  task automatic push_beat(input logic [1:0] t, input logic [31:0] a, input logic [3:0] route,
                           input int stalls, input logic resp, input logic [31:0] rdata);
    rsp_t r;
    bt_q.push_back(t);
    ba_q.push_back(a);
    exp_route_q.push_back(route);
    if (t == HTRANS_NONSEQ || t == HTRANS_SEQ) begin
      r.stalls = 8'(stalls);
      r.resp1  = resp;
      r.resp2  = resp;
      r.rdata  = rdata;
      exp_q.push_back(r);
    end
  endtask

  // Pipelined master: issues queued beats, records routing at acceptance and each data-phase response.
  task automatic run_bus(input string name);
    int   bi, cyc;
    logic pend, first;
    rsp_t cur;
    bi = 0; cyc = 0; pend = 1'b0; first = 1'b0; cur = '0;
    while ((bi < bt_q.size() || pend) && cyc < 200) begin
      src_htrans = (bi < bt_q.size()) ? bt_q[bi] : HTRANS_IDLE;
      src_haddr  = (bi < ba_q.size()) ? ba_q[bi] : 32'h0;
      @(negedge clk);
      if (pend) begin
        if (first) begin
          cur.resp1 = src_hresp;
          first = 1'b0;
        end
        if (!src_hready_resp) cur.stalls = cur.stalls + 8'd1;
      end
      if (src_hready) begin
        if (pend) begin
          cur.resp2 = src_hresp;
          cur.rdata = src_hrdata;
          obs_q.push_back(cur);
        end
        if (bi < bt_q.size()) begin
          obs_route_q.push_back(dst_htrans);
          pend = bt_q[bi][1];
          bi++;
        end else begin
          pend = 1'b0;
        end
        cur = '0;
        first = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 200) begin
      checks++; errors++;
      $display("FAIL %s_timeout: actual %0d cycles required under 200", name, cyc);
    end
    src_htrans = HTRANS_IDLE;
    bt_q.delete();
    ba_q.delete();
  endtask

  task automatic test_reset;
    logic [63:0] exp_addr;
    rst = 1'b1;
    src_htrans = HTRANS_IDLE; src_haddr = 32'h2000_0044; src_hwrite = 1'b1;
    src_hsize = 3'd2; src_hburst = 3'd1; src_hprot = 4'h3; src_hmastlock = 1'b1;
    src_hwdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    exp_addr = {2{32'h2000_0044}};
    checks++; if (src_hready_resp !== 1'b1) begin errors++; $display("FAIL reset_hready: actual %b required 1", src_hready_resp); end
    checks++; if (src_hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp: actual %b required 0", src_hresp); end
    checks++; if (src_hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: actual %h required 0", src_hrdata); end
    checks++; if (dst_htrans !== 4'b0000) begin errors++; $display("FAIL reset_htrans: actual %b required 0000", dst_htrans); end
    checks++; if (dst_haddr !== exp_addr) begin errors++; $display("FAIL bcast_haddr: actual %h required %h", dst_haddr, exp_addr); end
    checks++; if (dst_hwdata !== {2{32'hDEAD_BEEF}}) begin errors++; $display("FAIL bcast_hwdata: actual %h required %h", dst_hwdata, {2{32'hDEAD_BEEF}}); end
    checks++; if ({dst_hwrite, dst_hmastlock, dst_hready} !== 6'b111111) begin errors++; $display("FAIL bcast_ctrl: actual %b required 111111", {dst_hwrite, dst_hmastlock, dst_hready}); end
    checks++; if ({dst_hprot, dst_hsize, dst_hburst} !== {8'h33, 6'o22, 6'o11}) begin errors++; $display("FAIL bcast_attr: actual %h required %h", {dst_hprot, dst_hsize, dst_hburst}, {8'h33, 6'o22, 6'o11}); end
    @(posedge clk); #1;
    rst = 1'b0; src_hwrite = 1'b0; src_hmastlock = 1'b0; src_hburst = 3'd0;
  endtask

  task automatic test_read_wait;
    rsp_t e, o;
    logic [3:0] er;
    wait_cfg[1] = 4'd2;
    push_beat(HTRANS_NONSEQ, 32'h2000_0010, 4'b1000, 2, 1'b0, 32'hCAFE_F00D);
    run_bus("read_wait");
    while (exp_route_q.size() != 0) begin
      er = exp_route_q.pop_front(); checks++;
      if (obs_route_q.size() == 0) begin errors++; $display("FAIL read_wait_route: actual none required %b", er); end
      else if (obs_route_q[0] !== er) begin errors++; $display("FAIL read_wait_route: actual %b required %b", obs_route_q.pop_front(), er); end
      else void'(obs_route_q.pop_front());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL read_wait_rsp: actual none required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL read_wait_rsp: actual %h required %h", o, e); end end
    end
    wait_cfg[1] = 4'd0;
  endtask

  task automatic test_decode_error;
    rsp_t e, o;
    logic [3:0] er;
    push_beat(HTRANS_NONSEQ, 32'h4000_0000, 4'b0000, 1, 1'b1, 32'h0);
    push_beat(HTRANS_NONSEQ, 32'h0000_0000, 4'b0010, 0, 1'b0, 32'h1111_2222);
    run_bus("decode_err");
    while (exp_route_q.size() != 0) begin
      er = exp_route_q.pop_front(); checks++;
      if (obs_route_q.size() == 0) begin errors++; $display("FAIL decode_err_route: actual none required %b", er); end
      else if (obs_route_q[0] !== er) begin errors++; $display("FAIL decode_err_route: actual %b required %b", obs_route_q.pop_front(), er); end
      else void'(obs_route_q.pop_front());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL decode_err_rsp: actual none required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL decode_err_rsp: actual %h required %h", o, e); end end
    end
  endtask

  task automatic test_burst_lock;
    rsp_t e, o;
    logic [3:0] er;
    wait_cfg[1] = 4'd1;
    src_hburst = 3'b011;
    push_beat(HTRANS_NONSEQ, 32'h2000_0000, 4'b1000, 1, 1'b0, 32'hCAFE_F00D);
    push_beat(HTRANS_SEQ,    32'h2000_0004, 4'b1100, 1, 1'b0, 32'hCAFE_F00D);
    push_beat(HTRANS_BUSY,   32'h2000_0008, 4'b0100, 0, 1'b0, 32'h0);
    push_beat(HTRANS_SEQ,    32'h0000_0008, 4'b1100, 1, 1'b0, 32'hCAFE_F00D);
    push_beat(HTRANS_SEQ,    32'h2000_000C, 4'b1100, 1, 1'b0, 32'hCAFE_F00D);
    run_bus("burst");
    while (exp_route_q.size() != 0) begin
      er = exp_route_q.pop_front(); checks++;
      if (obs_route_q.size() == 0) begin errors++; $display("FAIL burst_route: actual none required %b", er); end
      else if (obs_route_q[0] !== er) begin errors++; $display("FAIL burst_route: actual %b required %b", obs_route_q.pop_front(), er); end
      else void'(obs_route_q.pop_front());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL burst_rsp: actual none required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL burst_rsp: actual %h required %h", o, e); end end
    end
    src_hburst = 3'b000;
    wait_cfg[1] = 4'd0;
  endtask

  task automatic test_overlap;
    src_htrans = HTRANS_NONSEQ;
    src_haddr  = 32'h2000_0000;
    @(negedge clk);
    checks++; if (ovl_htrans !== 4'b0010) begin errors++; $display("FAIL overlap_port1_addr: actual %b required 0010", ovl_htrans); end
    src_haddr = 32'h4000_0000;
    #1;
    checks++; if (ovl_htrans !== 4'b0010) begin errors++; $display("FAIL overlap_unmapped_addr: actual %b required 0010", ovl_htrans); end
    src_htrans = HTRANS_IDLE;
    @(posedge clk); #1;
  endtask

  task automatic test_double_error;
    rsp_t e, o;
    logic [3:0] er;
    push_beat(HTRANS_NONSEQ, 32'h4000_0000, 4'b0000, 1, 1'b1, 32'h0);
    push_beat(HTRANS_NONSEQ, 32'h5000_0000, 4'b0000, 1, 1'b1, 32'h0);
    push_beat(HTRANS_NONSEQ, 32'h0000_0004, 4'b0010, 0, 1'b0, 32'h1111_2222);
    run_bus("double_err");
    while (exp_route_q.size() != 0) begin
      er = exp_route_q.pop_front(); checks++;
      if (obs_route_q.size() == 0) begin errors++; $display("FAIL double_err_route: actual none required %b", er); end
      else if (obs_route_q[0] !== er) begin errors++; $display("FAIL double_err_route: actual %b required %b", obs_route_q.pop_front(), er); end
      else void'(obs_route_q.pop_front());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL double_err_rsp: actual none required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL double_err_rsp: actual %h required %h", o, e); end end
    end
  endtask

  task automatic test_back_to_back;
    rsp_t e, o;
    logic [3:0] er;
    wait_cfg[1] = 4'd1;
    push_beat(HTRANS_NONSEQ, 32'h0000_0000, 4'b0010, 0, 1'b0, 32'h1111_2222);
    push_beat(HTRANS_NONSEQ, 32'h2000_0000, 4'b1000, 1, 1'b0, 32'hCAFE_F00D);
    push_beat(HTRANS_NONSEQ, 32'h0000_0010, 4'b0010, 0, 1'b0, 32'h1111_2222);
    run_bus("b2b");
    while (exp_route_q.size() != 0) begin
      er = exp_route_q.pop_front(); checks++;
      if (obs_route_q.size() == 0) begin errors++; $display("FAIL b2b_route: actual none required %b", er); end
      else if (obs_route_q[0] !== er) begin errors++; $display("FAIL b2b_route: actual %b required %b", obs_route_q.pop_front(), er); end
      else void'(obs_route_q.pop_front());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_rsp: actual none required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL b2b_rsp: actual %h required %h", o, e); end end
    end
    wait_cfg[1] = 4'd0;
  endtask

  task automatic test_slave_error;
    rsp_t e, o;
    wait_cfg[0] = 4'd1;
    err_cfg[0]  = 1'b1;
    push_beat(HTRANS_NONSEQ, 32'h0000_0020, 4'b0010, 1, 1'b1, 32'h1111_2222);
    run_bus("slave_err");
    void'(exp_route_q.pop_front());
    checks++;
    if (obs_route_q.size() == 0) begin errors++; $display("FAIL slave_err_route: actual none required 0010"); end
    else begin
      if (obs_route_q[0] !== 4'b0010) begin errors++; $display("FAIL slave_err_route: actual %b required 0010", obs_route_q[0]); end
      void'(obs_route_q.pop_front());
    end
    e = exp_q.pop_front(); checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL slave_err_rsp: actual none required %h", e); end
    else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL slave_err_rsp: actual %h required %h", o, e); end end
    wait_cfg[0] = 4'd0;
    err_cfg[0]  = 1'b0;
  endtask

  task automatic test_reset_mid;
    wait_cfg[1] = 4'd3;
    src_htrans = HTRANS_NONSEQ; src_haddr = 32'h2000_0000;
    @(posedge clk); #1;
    src_htrans = HTRANS_IDLE;
    @(negedge clk);
    checks++; if (src_hready_resp !== 1'b0) begin errors++; $display("FAIL mid_wait_stall: actual %b required 0", src_hready_resp); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if ({src_hready_resp, src_hresp} !== 2'b10) begin errors++; $display("FAIL mid_wait_reset_resp: actual %b required 10", {src_hready_resp, src_hresp}); end
    checks++; if (src_hrdata !== 32'h0) begin errors++; $display("FAIL mid_wait_reset_rdata: actual %h required 0", src_hrdata); end
    wait_cfg[1] = 4'd0;
    src_htrans = HTRANS_NONSEQ; src_haddr = 32'h4000_0000;
    @(posedge clk); #1;
    src_htrans = HTRANS_IDLE;
    @(negedge clk);
    checks++; if ({src_hready_resp, src_hresp} !== 2'b01) begin errors++; $display("FAIL err1_before_reset: actual %b required 01", {src_hready_resp, src_hresp}); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if ({src_hready_resp, src_hresp} !== 2'b10) begin errors++; $display("FAIL err_reset_resp: actual %b required 10", {src_hready_resp, src_hresp}); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_cfg[0] = 4'd0; wait_cfg[1] = 4'd0;
    err_cfg[0]  = 1'b0; err_cfg[1]  = 1'b0;
    rdata_cfg[0] = 32'h1111_2222;
    rdata_cfg[1] = 32'hCAFE_F00D;
    test_reset();
    test_read_wait();
    test_decode_error();
    test_burst_lock();
    test_overlap();
    test_double_error();
    test_back_to_back();
    test_slave_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
